// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller
// Sits between the SPI peripheral byte stream and the BNN inference core.
// It decodes host opcodes, streams image payload bytes into the image
// buffer, launches inference, and captures the classification result.
// The live status byte is presented on tx_byte so the host can read it back.
//
// Ports:
//   clk, rst_n    system clock; asynchronous active-low reset
//   rx_byte       byte received from the SPI peripheral
//   byte_valid    one-cycle pulse that qualifies rx_byte
//   spi_error     SPI peripheral error flag (level; only its rising edge acts)
//   tx_byte       registered status {busy, result_valid, error, img_loaded, result[3:0]}
//   img_wr_en     image buffer write strobe
//   img_wr_addr   image buffer write address
//   img_wr_data   image buffer write data
//   infer_start   one-cycle inference launch pulse
//   infer_done    one-cycle completion pulse from the core
//   infer_result  class index; valid while infer_done is high
//   dbg_state     current FSM state encoding
module spi_cmd_controller #(
  parameter int          IMG_BYTES    = 113,
  parameter int          ADDR_W       = 7,
  parameter logic [15:0] BYTE_TIMEOUT = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              byte_valid,
  input  logic              spi_error,
  output logic [7:0]        tx_byte,
  output logic              img_wr_en,
  output logic [ADDR_W-1:0] img_wr_addr,
  output logic [7:0]        img_wr_data,
  output logic              infer_start,
  input  logic              infer_done,
  input  logic [3:0]        infer_result,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;

  localparam logic [7:0] OP_IMG_LOAD = 8'h01;
  localparam logic [7:0] OP_START    = 8'h02;
  localparam logic [7:0] OP_READ     = 8'h03;
  localparam logic [7:0] OP_CLEAR    = 8'h04;

  // The counter is one bit wider than the address so that it can hold
  // IMG_BYTES itself, even when IMG_BYTES equals 2^ADDR_W.
  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_BYTES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] byte_cnt;
  logic [15:0]      idle_cnt;
  logic             busy;
  logic             result_valid;
  logic             error_flag;
  logic             img_loaded;
  logic [3:0]       result;
  logic             spi_error_q;
  logic             spi_err_rise;

  assign spi_err_rise = spi_error & ~spi_error_q;
  assign dbg_state    = state;

  // The strobes default low every cycle, so each one is a single-cycle pulse.
  // The state machine only raises img_wr_en in LOAD and infer_start on the
  // IDLE->START transition, so the two strobes can never be high together.
  // A rising edge of spi_error takes priority over a byte in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      error_flag   <= 1'b0;
      img_loaded   <= 1'b0;
      result       <= 4'd0;
      spi_error_q  <= 1'b0;
      tx_byte      <= 8'h00;
      img_wr_en    <= 1'b0;
      img_wr_addr  <= '0;
      img_wr_data  <= 8'h00;
      infer_start  <= 1'b0;
    end else begin
      spi_error_q <= spi_error;
      img_wr_en   <= 1'b0;
      infer_start <= 1'b0;
      tx_byte     <= {busy, result_valid, error_flag, img_loaded, result};

      case (state)
        S_IDLE: begin
          if (spi_err_rise) begin
            error_flag <= 1'b1;
          end else if (byte_valid) begin
            case (rx_byte)
              OP_IMG_LOAD: begin
                byte_cnt     <= '0;
                idle_cnt     <= '0;
                img_loaded   <= 1'b0;
                result_valid <= 1'b0;
                state        <= S_LOAD;
              end
              OP_START: begin
                if (img_loaded) begin
                  infer_start <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_START;
                end else begin
                  error_flag <= 1'b1;
                end
              end
              OP_READ: ;
              OP_CLEAR: begin
                error_flag   <= 1'b0;
                img_loaded   <= 1'b0;
                result_valid <= 1'b0;
                result       <= 4'd0;
              end
              default: error_flag <= 1'b1;
            endcase
          end
        end

        // Payload bytes are written out raw, and they are never decoded as
        // opcodes. When the last byte's write is issued, img_loaded rises on
        // the same edge. When the link goes quiet, the load is abandoned and
        // the partial image is left in the buffer.
        S_LOAD: begin
          if (spi_err_rise) begin
            error_flag <= 1'b1;
            img_loaded <= 1'b0;
            state      <= S_IDLE;
          end else if (byte_valid) begin
            img_wr_en   <= 1'b1;
            img_wr_addr <= byte_cnt[ADDR_W-1:0];
            img_wr_data <= rx_byte;
            byte_cnt    <= byte_cnt + 1'b1;
            idle_cnt    <= '0;
            if (byte_cnt == LAST_IDX) begin
              img_loaded <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (idle_cnt == BYTE_TIMEOUT - 16'd1) begin
            error_flag <= 1'b1;
            img_loaded <= 1'b0;
            state      <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end

        // infer_start is already high during this cycle. This state only
        // hands control over to BUSY, unless the link faults first.
        S_START: begin
          if (spi_err_rise) begin
            error_flag <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            state <= S_BUSY;
          end
        end

        // The core keeps running whatever the host does. If a byte arrives
        // in the same cycle as infer_done, the byte is dropped. Other stray
        // bytes, and link faults, only set the error flag.
        S_BUSY: begin
          if (spi_err_rise) begin
            error_flag <= 1'b1;
          end
          if (infer_done) begin
            result       <= infer_result;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else if (byte_valid && (rx_byte != OP_READ)) begin
            error_flag <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// tb_spi_cmd_controller
// Directed testbench for spi_cmd_controller. Each task drives one scenario
// and compares the DUT outputs against hand-computed status bytes.
// Inputs change 1 time unit after the rising clock edge, and outputs are
// sampled at that same point.
module tb_spi_cmd_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       byte_valid = 1'b0;
  logic       spi_error = 1'b0;
  logic [7:0] tx_byte;
  logic       img_wr_en;
  logic [6:0] img_wr_addr;
  logic [7:0] img_wr_data;
  logic       infer_start;
  logic       infer_done = 1'b0;
  logic [3:0] infer_result = 4'd0;
  logic [2:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int wr_pulses = 0;
  int start_pulses = 0;
  int overlap = 0;

  spi_cmd_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .byte_valid   (byte_valid),
    .spi_error    (spi_error),
    .tx_byte      (tx_byte),
    .img_wr_en    (img_wr_en),
    .img_wr_addr  (img_wr_addr),
    .img_wr_data  (img_wr_data),
    .infer_start  (infer_start),
    .infer_done   (infer_done),
    .infer_result (infer_result),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  // Count strobe pulses so the tasks can check how many writes or launches happened.
  always @(posedge clk) begin
    if (img_wr_en) wr_pulses <= wr_pulses + 1;
    if (infer_start) start_pulses <= start_pulses + 1;
    if (img_wr_en && infer_start) overlap <= overlap + 1;
  end

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] r);
    infer_result = r;
    infer_done   = 1'b1;
    tick();
    infer_done   = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; byte_valid = 1'b0; spi_error = 1'b0; infer_done = 1'b0;
    rx_byte = 8'h00; infer_result = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sends IMG_LOAD plus a full payload of byte i at address i. When chk is
  // set, each write strobe is checked as it appears, one cycle after its byte.
  task automatic load_image(input bit chk);
    send_byte(8'h01);
    for (int i = 0; i < 113; i++) begin
      send_byte(8'(i));
      if (chk) begin
        n_vec++;
        if (img_wr_en !== 1'b1 || img_wr_addr !== 7'(i) || img_wr_data !== 8'(i)) begin
          n_err++;
          $display("[TB] FAIL load_write[%0d]: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                   i, img_wr_en, img_wr_addr, img_wr_data, i, i);
        end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    repeat (4) tick();
    n_vec++;
    if (tx_byte !== 8'h00) begin n_err++; $display("[TB] FAIL reset_tx: got %h expected 00", tx_byte); end
    n_vec++;
    if (dbg_state !== 3'd0) begin n_err++; $display("[TB] FAIL reset_state: got %0d expected 0", dbg_state); end
    n_vec++;
    if (img_wr_en !== 1'b0 || infer_start !== 1'b0 || wr_pulses != 0 || start_pulses != 0) begin
      n_err++;
      $display("[TB] FAIL reset_strobes: got en=%b start=%b wr=%0d st=%0d expected all 0",
               img_wr_en, infer_start, wr_pulses, start_pulses);
    end
  endtask

  task automatic test_load();
    int w0;
    w0 = wr_pulses;
    load_image(1'b1);
    n_vec++;
    if (wr_pulses - w0 != 113) begin n_err++; $display("[TB] FAIL load_count: got %0d expected 113", wr_pulses - w0); end
    n_vec++;
    if (tx_byte !== 8'h10) begin n_err++; $display("[TB] FAIL load_tx: got %h expected 10", tx_byte); end
    n_vec++;
    if (dbg_state !== 3'd0) begin n_err++; $display("[TB] FAIL load_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_start_result();
    int s0;
    s0 = start_pulses;
    send_byte(8'h02);
    n_vec++;
    if (infer_start !== 1'b1 || dbg_state !== 3'd2) begin
      n_err++; $display("[TB] FAIL start_pulse: got start=%b state=%0d expected start=1 state=2", infer_start, dbg_state);
    end
    tick();
    n_vec++;
    if (infer_start !== 1'b0 || dbg_state !== 3'd3) begin
      n_err++; $display("[TB] FAIL start_single: got start=%b state=%0d expected start=0 state=3", infer_start, dbg_state);
    end
    n_vec++;
    if (tx_byte !== 8'h90) begin n_err++; $display("[TB] FAIL busy_tx: got %h expected 90", tx_byte); end
    pulse_done(4'd7);
    n_vec++;
    if (tx_byte !== 8'h57 || dbg_state !== 3'd0) begin
      n_err++; $display("[TB] FAIL result_tx: got tx=%h state=%0d expected tx=57 state=0", tx_byte, dbg_state);
    end
    n_vec++;
    if (start_pulses - s0 != 1) begin n_err++; $display("[TB] FAIL start_count: got %0d expected 1", start_pulses - s0); end
  endtask

  task automatic test_no_image();
    int s0;
    do_reset();
    s0 = start_pulses;
    send_byte(8'h02);
    tick();
    n_vec++;
    if (start_pulses != s0 || tx_byte !== 8'h20 || dbg_state !== 3'd0) begin
      n_err++; $display("[TB] FAIL start_no_img: got starts=%0d tx=%h state=%0d expected starts=%0d tx=20 state=0",
                        start_pulses, tx_byte, dbg_state, s0);
    end
    send_byte(8'h04);
    tick();
    n_vec++;
    if (tx_byte !== 8'h00) begin n_err++; $display("[TB] FAIL clear_tx: got %h expected 00", tx_byte); end
    send_byte(8'hAB);
    tick();
    n_vec++;
    if (tx_byte !== 8'h20) begin n_err++; $display("[TB] FAIL bad_opcode_tx: got %h expected 20", tx_byte); end
    send_byte(8'h03);
    tick();
    n_vec++;
    if (tx_byte !== 8'h20 || dbg_state !== 3'd0) begin
      n_err++; $display("[TB] FAIL read_noop: got tx=%h state=%0d expected tx=20 state=0", tx_byte, dbg_state);
    end
  endtask

  task automatic test_timeout();
    int w0;
    int cnt;
    do_reset();
    w0 = wr_pulses;
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'hC0 + 8'(i));
    tick();
    n_vec++;
    if (wr_pulses - w0 != 10 || dbg_state !== 3'd1) begin
      n_err++; $display("[TB] FAIL partial_load: got writes=%0d state=%0d expected writes=10 state=1", wr_pulses - w0, dbg_state);
    end
    cnt = 1;
    while (dbg_state !== 3'd0 && cnt < 60000) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt < 49990 || cnt > 50010) begin
      n_err++; $display("[TB] FAIL timeout_cycles: got %0d expected about 50000", cnt);
    end
    tick();
    n_vec++;
    if (tx_byte !== 8'h20) begin n_err++; $display("[TB] FAIL timeout_tx: got %h expected 20", tx_byte); end
    w0 = wr_pulses;
    send_byte(8'h03);
    tick();
    n_vec++;
    if (wr_pulses != w0 || dbg_state !== 3'd0) begin
      n_err++; $display("[TB] FAIL post_timeout_byte: got writes=%0d state=%0d expected writes=0 state=0", wr_pulses - w0, dbg_state);
    end
  endtask

  // img_loaded stays set while BUSY, so an error during inference reads
  // back as busy|error|img_loaded = 0xB0.
  task automatic test_busy_error();
    do_reset();
    load_image(1'b0);
    send_byte(8'h02);
    tick();
    send_byte(8'h03);
    tick();
    n_vec++;
    if (tx_byte !== 8'h90 || dbg_state !== 3'd3) begin
      n_err++; $display("[TB] FAIL busy_read: got tx=%h state=%0d expected tx=90 state=3", tx_byte, dbg_state);
    end
    send_byte(8'h05);
    tick();
    n_vec++;
    if (tx_byte !== 8'hB0 || dbg_state !== 3'd3) begin
      n_err++; $display("[TB] FAIL busy_bad_byte: got tx=%h state=%0d expected tx=B0 state=3", tx_byte, dbg_state);
    end
    pulse_done(4'hA);
    n_vec++;
    if (tx_byte !== 8'h7A || dbg_state !== 3'd0) begin
      n_err++; $display("[TB] FAIL busy_done: got tx=%h state=%0d expected tx=7A state=0", tx_byte, dbg_state);
    end
  endtask

  task automatic test_simultaneous();
    int w0;
    send_byte(8'h02);
    tick();
    w0 = wr_pulses;
    infer_result = 4'd3; infer_done = 1'b1;
    rx_byte = 8'h01; byte_valid = 1'b1;
    tick();
    infer_done = 1'b0; byte_valid = 1'b0;
    tick();
    n_vec++;
    if (dbg_state !== 3'd0 || tx_byte !== 8'h73) begin
      n_err++; $display("[TB] FAIL done_and_byte: got state=%0d tx=%h expected state=0 tx=73", dbg_state, tx_byte);
    end
    tick();
    n_vec++;
    if (dbg_state !== 3'd0 || wr_pulses != w0) begin
      n_err++; $display("[TB] FAIL dropped_byte: got state=%0d writes=%0d expected state=0 writes=0", dbg_state, wr_pulses - w0);
    end
  endtask

  task automatic test_spi_error_load();
    send_byte(8'h04);
    tick();
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    spi_error = 1'b1;
    tick();
    spi_error = 1'b0;
    tick();
    n_vec++;
    if (dbg_state !== 3'd0 || tx_byte !== 8'h20) begin
      n_err++; $display("[TB] FAIL spi_err_load: got state=%0d tx=%h expected state=0 tx=20", dbg_state, tx_byte);
    end
  endtask

  task automatic test_busy_spi_err_and_reset();
    do_reset();
    load_image(1'b0);
    send_byte(8'h02);
    tick();
    spi_error = 1'b1;
    tick();
    spi_error = 1'b0;
    tick();
    n_vec++;
    if (dbg_state !== 3'd3 || tx_byte !== 8'hB0) begin
      n_err++; $display("[TB] FAIL spi_err_busy: got state=%0d tx=%h expected state=3 tx=B0", dbg_state, tx_byte);
    end
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (dbg_state !== 3'd0 || tx_byte !== 8'h00 || img_wr_en !== 1'b0 || infer_start !== 1'b0) begin
      n_err++; $display("[TB] FAIL async_reset: got state=%0d tx=%h expected state=0 tx=00", dbg_state, tx_byte);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_done(4'd5);
    tick();
    n_vec++;
    if (dbg_state !== 3'd0 || tx_byte !== 8'h00) begin
      n_err++; $display("[TB] FAIL stale_done: got state=%0d tx=%h expected state=0 tx=00", dbg_state, tx_byte);
    end
    n_vec++;
    if (overlap != 0) begin n_err++; $display("[TB] FAIL strobe_overlap: got %0d expected 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_start_result();
    test_no_image();
    test_timeout();
    test_busy_error();
    test_simultaneous();
    test_spi_error_load();
    test_busy_spi_err_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
